// File: rtl/mem_fetch_engine.sv
// Avalon-MM read engine: streams an A matrix into per-row FIFOs,
// then a B vector into one FIFO, one element per cycle.
module mem_fetch_engine #(
  parameter int DATA_WIDTH = 8,
  parameter int BUS_WIDTH  = 64,
  parameter int NUM_ROWS   = 8,
  parameter int ROW_LEN    = 8,
  parameter int ADDR_WIDTH = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [ADDR_WIDTH-1:0]          base_addr_a,
  input  logic [ADDR_WIDTH-1:0]          base_addr_b,
  output logic [ADDR_WIDTH-1:0]          avm_address,
  output logic                           avm_read,
  input  logic [BUS_WIDTH-1:0]           avm_readdata,
  input  logic                           avm_readdatavalid,
  input  logic                           avm_waitrequest,
  output logic [NUM_ROWS*DATA_WIDTH-1:0] fifo_a_data,
  output logic [NUM_ROWS-1:0]            fifo_a_wren,
  input  logic [NUM_ROWS-1:0]            fifo_a_full,
  output logic [DATA_WIDTH-1:0]          fifo_b_data,
  output logic                           fifo_b_wren,
  input  logic                           fifo_b_full,
  output logic                           busy,
  output logic                           done,
  output logic [2:0]                     state_out
);

  localparam int EPB = BUS_WIDTH / DATA_WIDTH;
  localparam int BPR = ROW_LEN / EPB;
  localparam int RW  = (NUM_ROWS > 1) ? $clog2(NUM_ROWS) : 1;
  localparam int BW  = (BPR > 1) ? $clog2(BPR) : 1;
  localparam int EW  = (EPB > 1) ? $clog2(EPB) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ   = 3'd1,
    S_WAIT  = 3'd2,
    S_DRAIN = 3'd3,
    S_DONE  = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [RW-1:0]         row_q, row_d;
  logic [BW-1:0]         beat_q, beat_d;
  logic [EW-1:0]         elem_q, elem_d;
  logic                  b_phase_q, b_phase_d;
  logic [ADDR_WIDTH-1:0] base_a_q, base_a_d;
  logic [ADDR_WIDTH-1:0] base_b_q, base_b_d;
  logic [BUS_WIDTH-1:0]  data_q, data_d;

  logic [DATA_WIDTH-1:0] elem;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic                  tgt_full;
  logic                  wr;
  logic                  row_last;
  logic                  beat_last;
  logic                  elem_last;

  // beat register shifts left on each write, so the MSB lane is always next
  assign elem      = data_q[BUS_WIDTH-1 -: DATA_WIDTH];
  assign tgt_full  = b_phase_q ? fifo_b_full : fifo_a_full[row_q];
  assign wr        = (state_q == S_DRAIN) && !tgt_full;
  assign row_last  = (row_q == RW'(NUM_ROWS - 1));
  assign beat_last = (beat_q == BW'(BPR - 1));
  assign elem_last = (elem_q == EW'(EPB - 1));

  always_comb begin
    req_addr = '0;
    if (b_phase_q) begin
      req_addr = base_b_q + ADDR_WIDTH'(beat_q);
    end else begin
      req_addr = base_a_q
               + ADDR_WIDTH'(row_q) * ADDR_WIDTH'(BPR)
               + ADDR_WIDTH'(beat_q);
    end
  end

  always_comb begin
    state_d   = state_q;
    row_d     = row_q;
    beat_d    = beat_q;
    elem_d    = elem_q;
    b_phase_d = b_phase_q;
    base_a_d  = base_a_q;
    base_b_d  = base_b_q;
    data_d    = data_q;
    unique case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          base_a_d  = base_addr_a;
          base_b_d  = base_addr_b;
          row_d     = '0;
          beat_d    = '0;
          elem_d    = '0;
          b_phase_d = 1'b0;
          state_d   = S_REQ;
        end
      end
      S_REQ: begin
        if (!avm_waitrequest) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (avm_readdatavalid) begin
          data_d  = avm_readdata;
          elem_d  = '0;
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (wr) begin
          data_d = data_q << DATA_WIDTH;
          elem_d = elem_q + EW'(1);
          if (elem_last) begin
            elem_d  = '0;
            state_d = S_REQ;
            if (!beat_last) begin
              beat_d = beat_q + BW'(1);
            end else begin
              beat_d = '0;
              if (b_phase_q) begin
                state_d = S_DONE;
              end else if (row_last) begin
                row_d     = '0;
                b_phase_d = 1'b1;
              end else begin
                row_d = row_q + RW'(1);
              end
            end
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      row_q     <= '0;
      beat_q    <= '0;
      elem_q    <= '0;
      b_phase_q <= 1'b0;
      base_a_q  <= '0;
      base_b_q  <= '0;
      data_q    <= '0;
    end else begin
      state_q   <= state_d;
      row_q     <= row_d;
      beat_q    <= beat_d;
      elem_q    <= elem_d;
      b_phase_q <= b_phase_d;
      base_a_q  <= base_a_d;
      base_b_q  <= base_b_d;
      data_q    <= data_d;
    end
  end

  always_comb begin
    avm_read    = (state_q == S_REQ);
    avm_address = avm_read ? req_addr : '0;
    fifo_a_data = '0;
    fifo_a_wren = '0;
    fifo_b_data = '0;
    fifo_b_wren = 1'b0;
    if (state_q == S_DRAIN) begin
      if (b_phase_q) begin
        fifo_b_data = elem;
        fifo_b_wren = wr;
      end else begin
        fifo_a_data[row_q*DATA_WIDTH +: DATA_WIDTH] = elem;
        fifo_a_wren[row_q] = wr;
      end
    end
  end

  assign busy      = (state_q == S_REQ) || (state_q == S_WAIT)
                  || (state_q == S_DRAIN);
  assign done      = (state_q == S_DONE);
  assign state_out = state_q;

endmodule

// File: doc/mem_fetch_engine.md
Name: mem_fetch_engine

Overview:
Parametrised Avalon-MM read engine that loads an A matrix (NUM_ROWS rows of ROW_LEN elements) into per-row A FIFOs, then a B vector (ROW_LEN elements) into one B FIFO, for the MAC array.
Successor to the fixed 8x8 fetch controller:
- generic element/bus width, row count and row length, so a row may span several bus beats
- programmable A and B base addresses
- correct waitrequest hold and FIFO-full backpressure
- restartable after done.

Parameters:
DATA_WIDTH, 8, bits per element
BUS_WIDTH, 64, Avalon readdata width; must be a multiple of DATA_WIDTH; EPB = BUS_WIDTH/DATA_WIDTH elements per beat
NUM_ROWS, 8, rows of A = number of A FIFOs
ROW_LEN, 8, elements per A row and in B; must be a multiple of EPB; BPR = ROW_LEN/EPB beats per row
ADDR_WIDTH, 32, Avalon word-address width

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
start  in  1  begin a load; sampled in IDLE or DONE only
base_addr_a  in  ADDR_WIDTH  word address of A row 0 beat 0; sampled when start is accepted
base_addr_b  in  ADDR_WIDTH  word address of B beat 0; sampled when start is accepted
avm_address  out  ADDR_WIDTH  read word address
avm_read  out  1  read request
avm_readdata  in  BUS_WIDTH  read data
avm_readdatavalid  in  1  read data valid
avm_waitrequest  in  1  slave stall
fifo_a_data  out  NUM_ROWS*DATA_WIDTH  row r data on slice [r*DATA_WIDTH +: DATA_WIDTH]
fifo_a_wren  out  NUM_ROWS  one-hot write enable
fifo_a_full  in  NUM_ROWS  per-row FIFO full
fifo_b_data  out  DATA_WIDTH  B FIFO data
fifo_b_wren  out  1  B FIFO write enable
fifo_b_full  in  1  B FIFO full
busy  out  1  high in REQ, WAIT and DRAIN
done  out  1  level; high in DONE
state_out  out  3  encoded state for debug

Behaviour:
- Single clock clk. Synchronous active-high reset rst; all flops update on posedge clk only.
- On rst:
  - state=IDLE; row/beat/element counters 0
  - avm_read=0, avm_address=0
  - all wren=0, all FIFO data outputs 0
  - busy=0, done=0
- rst mid-operation: aborts at the next edge. Late readdatavalid arriving in IDLE is ignored. FIFOs are not flushed by this block.
- Target sequence: A row 0 beats 0..BPR-1, row 1, ..., row NUM_ROWS-1, then B beats 0..BPR-1.
- Addresses:
  - A row r, beat k: base_addr_a + r*BPR + k
  - B beat k: base_addr_b + k
  - Computed modulo 2^ADDR_WIDTH; wrap is allowed.
- States and encodings: IDLE=0, REQ=1, WAIT=2, DRAIN=3, DONE=4.
  - IDLE: on start, latch both bases, clear counters, go to REQ.
  - REQ: avm_read=1, avm_address=current beat address. Both are held stable while avm_waitrequest=1. On a cycle with avm_waitrequest=0, go to WAIT; avm_read=0 from the next cycle.
  - WAIT: on avm_readdatavalid, capture avm_readdata into the beat register and go to DRAIN with element index e=0.
  - DRAIN: emit elements one per cycle, element e = beat[BUS_WIDTH-1-e*DATA_WIDTH -: DATA_WIDTH] (MSB lane first).
    - Write strobe is combinational: wren = (state==DRAIN) && !full[target]. Data presented the same cycle; e advances only when wren=1.
    - Target full: wren=0, e holds, stall indefinitely.
    - After e=EPB-1 is written:
      - more beats in the row or further rows remain: REQ
      - last B beat: DONE
- DONE: done=1. start returns to REQ with new bases and done drops the next cycle.
- Exactly one read is outstanding. avm_readdatavalid outside WAIT is ignored. start outside IDLE/DONE is ignored.
- fifo_a_data is driven only on the active row slice (others 0); fifo_b_data is 0 except in B DRAIN.
- Ideal latency, zero wait and no full: per beat 1 REQ + L WAIT + EPB DRAIN cycles, where L is the read latency in cycles.

Test Plan:
1. Defaults, base_a=0x100, base_b=0x200, memory word n = 64'h0n0n..., no stalls -> 9 reads at 0x100..0x107 then 0x200. Each A FIFO receives bytes MSB-first. B gets 8 bytes. done=1 after the last fifo_b_wren; total 64+8 writes.
2. ROW_LEN=16, NUM_ROWS=4 -> BPR=2. Reads at base_a+0..7 then base_b+0,1. Row r gets 16 elements from beats 2r, 2r+1 in order.
3. avm_waitrequest held 5 cycles on the first request -> avm_read and avm_address stable all 5 cycles. Exactly one read is accepted; no duplicate writes.
4. fifo_a_full[3] high for 10 cycles during row 3 drain -> fifo_a_wren[3]=0 throughout. Writing resumes at the same element; row 3 still receives exactly 8 bytes in order.
5. rst pulsed during row 2 WAIT, then readdatavalid arrives -> no wren and state stays IDLE. A new start produces a clean full load.
6. start while busy is ignored. start in DONE with base_a=0xFFFFFFFC -> addresses wrap 0xFFFFFFFC..0x00000003 and done re-asserts at the end.
